// File: rtl/mole_judge_if.sv
// Signal bundle between the whack-a-mole judge and its surroundings.
// The master drives the game inputs; the judge (slave) drives the ring and display controls.
interface mole_judge_if;
    logic       start;
    logic       tick;
    logic [9:0] mole_posit;
    logic [9:0] whack;
    logic       ring_reset;
    logic       ring_en;
    logic       hit;
    logic [7:0] score_bcd;
    logic [1:0] misses;
    logic       led_flash;
    logic       game_over;

    modport master (
        output start, tick, mole_posit, whack,
        input  ring_reset, ring_en, hit, score_bcd, misses, led_flash, game_over
    );

    modport slave (
        input  start, tick, mole_posit, whack,
        output ring_reset, ring_en, hit, score_bcd, misses, led_flash, game_over
    );
endinterface

// File: rtl/mole_judge.sv
// Whack-a-mole referee: times each mole, scores hits in BCD, counts misses and
// shrinks the visible window every tenth hit.
module mole_judge #(
    parameter int unsigned WINDOW_INIT = 200,
    parameter int unsigned WINDOW_MIN  = 40,
    parameter int unsigned WINDOW_STEP = 20,
    parameter int unsigned FLASH_TICKS = 50,
    parameter int unsigned MAX_MISSES  = 3
) (
    input logic         clk,
    input logic         judge_reset,
    mole_judge_if.slave bus
);

    localparam int unsigned FlashW = (FLASH_TICKS < 2) ? 1 : $clog2(FLASH_TICKS + 1);

    localparam logic [9:0]        WinInit   = 10'(WINDOW_INIT);
    localparam logic [9:0]        WinMin    = 10'(WINDOW_MIN);
    localparam logic [9:0]        WinStep   = 10'(WINDOW_STEP);
    localparam logic [10:0]       ShrinkThr = 11'(WINDOW_MIN + WINDOW_STEP);
    localparam logic [FlashW-1:0] FlashInit = FlashW'(FLASH_TICKS);
    localparam logic [1:0]        MissMax   = 2'(MAX_MISSES);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StShow,
        StFlash,
        StAdvance,
        StOver
    } state_e;

    state_e            state_q, state_d;
    logic [9:0]        whack_q, whack_d;
    logic [7:0]        score_q, score_d;
    logic [1:0]        misses_q, misses_d;
    logic [3:0]        hit_grp_q, hit_grp_d;
    logic [9:0]        window_q, window_d;
    logic [9:0]        win_cnt_q, win_cnt_d;
    logic [FlashW-1:0] flash_cnt_q, flash_cnt_d;
    logic              hit_q, hit_d;

    logic [9:0] whack_rise;
    logic       mole_valid;
    logic       miss;

    // Saturating two-digit BCD increment.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    assign whack_rise = bus.whack & ~whack_q;
    assign mole_valid = $onehot(bus.mole_posit);

    always_comb begin
        state_d     = state_q;
        whack_d     = bus.whack;
        score_d     = score_q;
        misses_d    = misses_q;
        hit_grp_d   = hit_grp_q;
        window_d    = window_q;
        win_cnt_d   = win_cnt_q;
        flash_cnt_d = flash_cnt_q;
        hit_d       = 1'b0;
        miss        = 1'b0;

        case (state_q)
            StIdle, StOver: begin
                if (bus.start) begin
                    state_d   = StArm;
                    score_d   = 8'h00;
                    misses_d  = 2'd0;
                    hit_grp_d = 4'd0;
                    window_d  = WinInit;
                end
            end

            StArm: begin
                win_cnt_d = window_q;
                state_d   = StShow;
            end

            StShow: begin
                // A whack edge outranks a coincident timeout tick.
                if (mole_valid) begin
                    if (whack_rise != 10'd0) begin
                        if (whack_rise == bus.mole_posit) begin
                            hit_d       = 1'b1;
                            score_d     = bcd_inc(score_q);
                            flash_cnt_d = FlashInit;
                            state_d     = StFlash;
                            if (hit_grp_q == 4'd9) begin
                                hit_grp_d = 4'd0;
                                window_d  = ({1'b0, window_q} >= ShrinkThr) ?
                                            window_q - WinStep : WinMin;
                            end else begin
                                hit_grp_d = hit_grp_q + 4'd1;
                            end
                        end else begin
                            miss = 1'b1;
                        end
                    end else if (bus.tick) begin
                        if (win_cnt_q <= 10'd1) begin
                            miss = 1'b1;
                        end else begin
                            win_cnt_d = win_cnt_q - 10'd1;
                        end
                    end
                end
                if (miss) begin
                    misses_d = misses_q + 2'd1;
                    state_d  = (misses_d == MissMax) ? StOver : StAdvance;
                end
            end

            StFlash: begin
                if (bus.tick) begin
                    if (flash_cnt_q <= FlashW'(1)) begin
                        state_d = StAdvance;
                    end else begin
                        flash_cnt_d = flash_cnt_q - FlashW'(1);
                    end
                end
            end

            StAdvance: begin
                win_cnt_d = window_q;
                state_d   = StShow;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge judge_reset) begin
        if (judge_reset) begin
            state_q     <= StIdle;
            whack_q     <= 10'd0;
            score_q     <= 8'h00;
            misses_q    <= 2'd0;
            hit_grp_q   <= 4'd0;
            window_q    <= WinInit;
            win_cnt_q   <= 10'd0;
            flash_cnt_q <= '0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            whack_q     <= whack_d;
            score_q     <= score_d;
            misses_q    <= misses_d;
            hit_grp_q   <= hit_grp_d;
            window_q    <= window_d;
            win_cnt_q   <= win_cnt_d;
            flash_cnt_q <= flash_cnt_d;
            hit_q       <= hit_d;
        end
    end

    // Pulses decode from exclusive states, so ring_en and ring_reset never overlap.
    assign bus.ring_reset = (state_q == StArm);
    assign bus.ring_en    = (state_q == StAdvance);
    assign bus.led_flash  = (state_q == StFlash);
    assign bus.game_over  = (state_q == StOver);
    assign bus.hit        = hit_q;
    assign bus.score_bcd  = score_q;
    assign bus.misses     = misses_q;

endmodule

// File: doc/mole_judge.md
MOLE_JUDGE -- requirements
Module: mole_judge

Interface
REQ-001 Parameter WINDOW_INIT, 200, initial mole-visible window in ticks (2..1023) SHALL be provided.
REQ-002 Parameter WINDOW_MIN, 40, floor for the shrinking window in ticks SHALL be provided.
REQ-003 Parameter WINDOW_STEP, 20, window reduction applied after every 10th hit SHALL be provided.
REQ-004 Parameter FLASH_TICKS, 50, hit-feedback duration in ticks SHALL be provided.
REQ-005 Parameter MAX_MISSES, 3, misses that end the game (1..3) SHALL be provided.
REQ-006 Port clk  in  1  single system clock; all state changes on its rising edge.
REQ-007 Port judge_reset  in  1  reset, asynchronous and active-high.
REQ-008 Port start  in  1  begin/restart game; sampled in IDLE and OVER only.
REQ-009 Port tick  in  1  one-cycle timebase strobe.
REQ-010 Port mole_posit  in  10  one-hot mole position from the ring counter.
REQ-011 Port whack  in  10  player switches, already synchronised and debounced.
REQ-012 Port ring_reset  out  1  one-cycle pulse re-seeding the ring counter to bit 0.
REQ-013 Port ring_en  out  1  one-cycle pulse advancing the ring counter one position.
REQ-014 Port hit  out  1  one-cycle pulse per scored hit.
REQ-015 Port score_bcd  out  8  two BCD digits {tens,units}, 00..99.
REQ-016 Port misses  out  2  miss count in the current game.
REQ-017 Port led_flash  out  1  high throughout FLASH.
REQ-018 Port game_over  out  1  high throughout OVER.

Function
REQ-019 FSM states SHALL be IDLE, ARM, SHOW, FLASH, ADVANCE, OVER.
REQ-020 Edge register whack_q SHALL update every cycle in all states; whack_rise = whack & ~whack_q; switches held on entry to SHOW never score.
REQ-021 IDLE/OVER: start=1 -> ARM; score_bcd, misses, hit-group counter cleared and window := WINDOW_INIT in the same edge.
REQ-022 ARM: ring_reset=1 for exactly that cycle -> SHOW; window counter loaded with current window.
REQ-023 SHOW: mole_valid = mole_posit exactly one-hot; while invalid, whacks ignored and window counter held.
REQ-024 SHOW hit: whack_rise == mole_posit (nonzero) -> hit=1 next cycle, score +1 BCD, -> FLASH.
REQ-025 SHOW miss: whack_rise nonzero and != mole_posit (includes mole bit plus any other bit) -> misses +1.
REQ-026 SHOW timeout: tick=1 with window counter ==1 -> misses +1; otherwise tick decrements counter.
REQ-027 Whack and timeout in the same cycle: whack outcome decides; only one event counted.
REQ-028 After a miss: new misses == MAX_MISSES -> OVER, else -> ADVANCE.
REQ-029 FLASH: counts FLASH_TICKS ticks, then -> ADVANCE; whacks ignored (edge register still updates).
REQ-030 ADVANCE: ring_en=1 for exactly that cycle -> SHOW, window counter reloaded.
REQ-031 Every 10th hit: window := max(window - WINDOW_STEP, WINDOW_MIN), effective from the next reload.
REQ-032 Score SHALL saturate at 99; hits beyond still pulse hit and still follow REQ-024.
REQ-033 ring_en and ring_reset SHALL never be asserted in the same cycle.

Reset
REQ-034 judge_reset=1 SHALL immediately force IDLE, whack_q=0, window=WINDOW_INIT, all outputs 0, including mid-game and during pulses.
REQ-035 First rising clk after deassertion SHALL evaluate IDLE normally.

Verification
REQ-036 Reset, start=1 one cycle -> ARM with ring_reset=1 one cycle, then SHOW, score_bcd=00, misses=0.
REQ-037 SHOW, mole_posit=0000000100, whack rises 0000000100 -> hit pulse, score_bcd=01, led_flash for 50 ticks, then ring_en one cycle.
REQ-038 SHOW, no whack, 200 ticks -> misses=1, ring_en one cycle; third such timeout -> game_over=1, no ring_en.
REQ-039 Whack rises 0000000110 with mole at bit 2, same cycle as final tick -> exactly one miss, no hit.
REQ-040 Switch held high across ADVANCE -> no hit; 10 hits -> next window 180 ticks; 99 hits +1 -> score_bcd stays 99.
REQ-041 judge_reset asserted mid-FLASH -> outputs 0 asynchronously, IDLE; start in OVER -> new game, counters cleared.
